// File: rtl/llc_pipe_ctrl_pkg.sv
// Shared LLC pipeline types and constants: stage entry record, default depth and field widths.
package llc_pipe_ctrl_pkg;

    localparam int LLC_PIPE_STAGES   = 4;
    localparam int LLC_SET_BITS_DFLT = 8;
    localparam int LLC_CH_BITS_DFLT  = 2;

    typedef struct packed {
        logic                         valid;
        logic [LLC_SET_BITS_DFLT-1:0] set;
        logic [LLC_CH_BITS_DFLT-1:0]  ch;
    } llc_pipe_entry_t;

    function automatic int llc_ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/llc_pipe_arbiter.sv
// Fixed-priority grant (index 0 highest) over requests that are not hazarded.
module llc_pipe_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] hazard,
    input  logic              en,
    output logic [NUM_CH-1:0] grant
);

    logic [NUM_CH-1:0] elig;

    assign elig = req & ~hazard;
    // Isolate the lowest set bit so hazarded channels never shadow lower-priority ones.
    assign grant = en ? (elig & (~elig + NUM_CH'(1))) : '0;

endmodule

// File: rtl/llc_pipe_ctrl.sv
// LLC request pipeline controller: set-hazard-aware channel issue into a bubble-collapsing stage pipe.
// Optional statistics counters are built when LLC_PIPE_STATS_EN is defined.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module llc_pipe_ctrl
    import llc_pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = LLC_PIPE_STAGES,
    parameter int NUM_CH     = 4,
    parameter int SET_BITS   = `LLC_SET_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH-1:0]                         ch_valid,
    input  logic [NUM_CH*SET_BITS-1:0]                ch_set,
    output logic [NUM_CH-1:0]                         ch_ready,
    input  logic                                      proc_done,
    input  logic                                      flush,
    output logic [NUM_STAGES-1:0]                     stage_valid,
    output logic [NUM_STAGES*SET_BITS-1:0]            stage_set,
    output logic [NUM_STAGES*llc_ch_bits(NUM_CH)-1:0] stage_ch,
    output logic                                      retire,
    output logic                                      busy
`ifdef LLC_PIPE_STATS_EN
    ,
    output logic [31:0]                               stat_issued,
    output logic [31:0]                               stat_retired,
    output logic [31:0]                               stat_hazard_cycles
`endif
);

    localparam int CH_BITS = llc_ch_bits(NUM_CH);
    localparam int LAST    = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0]               stg_vld_p;
    logic [NUM_STAGES-1:0][SET_BITS-1:0] stg_set_p;
    logic [NUM_STAGES-1:0][CH_BITS-1:0]  stg_ch_p;

    logic [NUM_STAGES-1:0] slot_free;
    logic [NUM_CH-1:0]     hazard;
    logic [NUM_CH-1:0]     grant;
    logic                  gnt_any;
    logic [SET_BITS-1:0]   gnt_set;
    logic [CH_BITS-1:0]    gnt_ch;

    // A slot is free when empty or when its occupant moves on this cycle.
    always_comb begin
        slot_free       = '0;
        slot_free[LAST] = ~stg_vld_p[LAST] | proc_done;
        for (int k = LAST - 1; k >= 0; k--) begin
            slot_free[k] = ~stg_vld_p[k] | slot_free[k+1];
        end
    end

    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (stg_vld_p[k] && (ch_set[i*SET_BITS +: SET_BITS] == stg_set_p[k])) begin
                    hazard[i] = 1'b1;
                end
            end
        end
    end

    llc_pipe_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req    (ch_valid),
        .hazard (hazard),
        .en     (slot_free[0] & ~flush & rst),
        .grant  (grant)
    );

    always_comb begin
        gnt_set = '0;
        gnt_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_set = ch_set[i*SET_BITS +: SET_BITS];
                gnt_ch  = CH_BITS'(i);
            end
        end
    end

    assign gnt_any = |grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_vld_p <= '0;
            stg_set_p <= '0;
            stg_ch_p  <= '0;
        end else begin
            // stage 0 boundary: accept the granted channel
            if (slot_free[0]) begin
                stg_vld_p[0] <= gnt_any;
                stg_set_p[0] <= gnt_set;
                stg_ch_p[0]  <= gnt_ch;
            end
            // stage k-1 -> k boundary
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (slot_free[k]) begin
                    stg_vld_p[k] <= stg_vld_p[k-1];
                    stg_set_p[k] <= stg_set_p[k-1];
                    stg_ch_p[k]  <= stg_ch_p[k-1];
                end
            end
            if (flush) begin
                stg_vld_p <= '0;
            end
        end
    end

    assign ch_ready    = grant;
    assign retire      = stg_vld_p[LAST] & proc_done;
    assign busy        = |stg_vld_p;
    assign stage_valid = stg_vld_p;
    assign stage_set   = stg_set_p;
    assign stage_ch    = stg_ch_p;

`ifdef LLC_PIPE_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_retired_q;
    logic [31:0] stat_hazard_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued_q  <= '0;
            stat_retired_q <= '0;
            stat_hazard_q  <= '0;
        end else begin
            stat_issued_q  <= sat_inc(stat_issued_q, gnt_any);
            stat_retired_q <= sat_inc(stat_retired_q, retire);
            stat_hazard_q  <= sat_inc(stat_hazard_q, |(ch_valid & hazard & ~grant));
        end
    end

    assign stat_issued        = stat_issued_q;
    assign stat_retired       = stat_retired_q;
    assign stat_hazard_cycles = stat_hazard_q;
`endif

endmodule
